// File: rtl/sp_ram_burst_master.sv
// rtl/sp_ram_burst_master.sv - burst initiator for a single-port RAM with valid/ready data streams
module sp_ram_burst_master #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]    cmd_len_i,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_be_i,
  output logic                    rd_valid_o,
  input  logic                    rd_ready_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    done_o,
  output logic                    busy_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFF;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  cnt;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  fifo_wptr;
  logic                  fifo_rptr;
  logic [1:0]            fifo_cnt;

  logic       cmd_fire;
  logic       wr_beat;
  logic       pop;
  logic       rd_issue;
  logic [2:0] occ_after;

  assign cmd_fire = cmd_valid_i & cmd_ready_o;
  assign wr_beat  = (state == S_WRITE) & wr_valid_i;
  assign pop      = rd_valid_o & rd_ready_i;

  // Outstanding words (buffered + in flight) once this cycle's pop retires; issuing
  // against this value keeps the total within two and still allows 1 word/cycle.
  assign occ_after = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign rd_issue  = (state == S_READ) && (cnt != '0) && (occ_after < 3'd2);

  always_comb begin
    cmd_ready_o = (state == S_IDLE);
    busy_o      = (state != S_IDLE);
    done_o      = (state == S_DONE);
    wr_ready_o  = (state == S_WRITE);
    ram_en_o    = wr_beat | rd_issue;
    ram_we_o    = wr_beat;
    ram_addr_o  = (state == S_WRITE || state == S_READ) ? addr : '0;
    ram_wdata_o = (state == S_WRITE) ? wr_data_i : '0;
    ram_be_o    = '0;
    if (state == S_WRITE) ram_be_o = wr_be_i;
    else if (rd_issue)    ram_be_o = '1;
    // The word arriving this cycle is already visible at the head when the buffer is empty.
    rd_valid_o  = (fifo_cnt != 2'd0) | inflight;
    rd_data_o   = '0;
    if (fifo_cnt != 2'd0) rd_data_o = fifo_mem[fifo_rptr];
    else if (inflight)    rd_data_o = ram_rdata_i;
  end

  always_ff @(posedge clk) begin
    if (inflight) fifo_mem[fifo_wptr] <= ram_rdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      cnt       <= '0;
      inflight  <= 1'b0;
      fifo_wptr <= 1'b0;
      fifo_rptr <= 1'b0;
      fifo_cnt  <= 2'd0;
    end else begin
      inflight <= rd_issue;
      fifo_cnt <= occ_after[1:0];
      if (inflight) fifo_wptr <= ~fifo_wptr;
      if (pop)      fifo_rptr <= ~fifo_rptr;
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            addr <= cmd_addr_i & ADDR_MASK;
            cnt  <= cmd_len_i;
            if (cmd_len_i == '0) state <= S_DONE;
            else if (cmd_write_i) state <= S_WRITE;
            else state <= S_READ;
          end
        end
        S_WRITE: begin
          if (wr_beat) begin
            addr <= addr + ADDR_STEP;
            cnt  <= cnt - LEN_WIDTH'(1);
            if (cnt == LEN_WIDTH'(1)) state <= S_DONE;
          end
        end
        S_READ: begin
          if (rd_issue) begin
            addr <= addr + ADDR_STEP;
            cnt  <= cnt - LEN_WIDTH'(1);
          end
          if (cnt == '0 && occ_after == 3'd0) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sp_ram_burst_master.sv
// tb/tb_sp_ram_burst_master.sv - directed vector bench for sp_ram_burst_master
module tb_sp_ram_burst_master;
  logic        clk;
  logic        rst;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [21:0] cmd_addr_i;
  logic [7:0]  cmd_len_i;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [31:0] wr_data_i;
  logic [3:0]  wr_be_i;
  logic        rd_valid_o;
  logic        rd_ready_i;
  logic [31:0] rd_data_o;
  logic        done_o;
  logic        busy_o;
  logic        ram_en_o;
  logic [21:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic        ram_we_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_rdata_i;

  int checks = 0;
  int failures = 0;

  sp_ram_burst_master #(.ADDR_WIDTH(22), .DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i), .wr_be_i(wr_be_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
    .done_o(done_o), .busy_o(busy_o),
    .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM keyed by word address, read data registered one cycle after enable.
  logic [31:0] ram_mem [int];
  logic [31:0] ram_w;
  int          ram_k;
  always @(posedge clk) begin
    if (ram_en_o) begin
      ram_k = int'(ram_addr_o >> 2);
      if (ram_we_o) begin
        ram_w = ram_mem.exists(ram_k) ? ram_mem[ram_k] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) ram_w[8*b +: 8] = ram_wdata_o[8*b +: 8];
        ram_mem[ram_k] = ram_w;
      end else begin
        ram_rdata_i <= ram_mem.exists(ram_k) ? ram_mem[ram_k] : 32'hDEADBEEF;
      end
    end
  end

  typedef struct {
    logic        wr;
    logic [21:0] addr;
    logic [7:0]  len;
    logic [31:0] data0;
    logic [3:0]  be;
    logic [21:0] exp_addr0;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mkv(logic wr, logic [21:0] a, logic [7:0] l, logic [31:0] d,
                               logic [3:0] be, logic [21:0] ea);
    vec_t v;
    v.wr = wr; v.addr = a; v.len = l; v.data0 = d; v.be = be; v.exp_addr0 = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [21:0] a, input logic [7:0] l);
    @(posedge clk); #1;
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = a; cmd_len_i = l;
  endtask

  // Streams never stall: checks addresses, data, beat cadence and done timing.
  task automatic run_vec(input vec_t v, input int idx);
    int beats, rx, done_cyc, exp_done;
    logic [21:0] ea;
    beats = 0; rx = 0; done_cyc = 0;
    send_cmd(v.wr, v.addr, v.len);
    rd_ready_i = 1'b1; wr_valid_i = v.wr; wr_data_i = v.data0; wr_be_i = v.be;
    @(negedge clk);
    chk($sformatf("v%0d_cmd_ready", idx), {31'b0, cmd_ready_o}, 32'd1);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      chk($sformatf("v%0d_busy", idx), {31'b0, busy_o}, 32'd1);
      if (ram_en_o) begin
        ea = v.exp_addr0 + 22'(beats * 4);
        chk($sformatf("v%0d_addr%0d", idx, beats), {10'b0, ram_addr_o}, {10'b0, ea});
        chk($sformatf("v%0d_we%0d", idx, beats), {31'b0, ram_we_o}, {31'b0, v.wr});
        chk($sformatf("v%0d_cadence%0d", idx, beats), cyc, beats + 1);
        if (v.wr) begin
          chk($sformatf("v%0d_wdata%0d", idx, beats), ram_wdata_o, v.data0 + beats);
          chk($sformatf("v%0d_be%0d", idx, beats), {28'b0, ram_be_o}, {28'b0, v.be});
        end
        beats++;
      end
      if (rd_valid_o && rd_ready_i) begin
        chk($sformatf("v%0d_rdata%0d", idx, rx), rd_data_o, v.data0 + rx);
        chk($sformatf("v%0d_rdcyc%0d", idx, rx), cyc, rx + 2);
        rx++;
      end
      if (done_o) done_cyc = cyc;
      @(posedge clk); #1;
      wr_data_i = v.data0 + beats;
    end
    wr_valid_i = 1'b0;
    exp_done = (v.len == 0) ? 1 : (v.wr ? int'(v.len) + 1 : int'(v.len) + 2);
    chk($sformatf("v%0d_beats", idx), beats, int'(v.len));
    if (!v.wr) chk($sformatf("v%0d_rx", idx), rx, int'(v.len));
    chk($sformatf("v%0d_done_cyc", idx), done_cyc, exp_done);
    @(negedge clk);
    chk($sformatf("v%0d_idle_ready", idx), {30'b0, busy_o, cmd_ready_o}, 32'd1);
  endtask

  task automatic toggle_read();
    int issued, popped, outstanding, stalls, done_cyc, pop_now;
    issued = 0; popped = 0; stalls = 0; done_cyc = 0;
    send_cmd(1'b0, 22'h200000, 8'd8);
    rd_ready_i = 1'b1;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    for (int cyc = 1; cyc <= 60 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      outstanding = issued - popped;
      pop_now = (rd_valid_o && rd_ready_i) ? 1 : 0;
      chk("tog_outstanding_le2", {31'b0, outstanding <= 2}, 32'd1);
      chk("tog_valid", {31'b0, rd_valid_o}, {31'b0, outstanding > 0});
      if (outstanding - pop_now >= 2) begin
        chk("tog_stall_full", {31'b0, ram_en_o}, 32'd0);
        stalls++;
      end
      if (outstanding == 0 && issued < 8)
        chk("tog_issue_empty", {31'b0, ram_en_o}, 32'd1);
      if (ram_en_o) begin
        chk("tog_addr", {10'b0, ram_addr_o}, 32'h200000 + 32'(issued * 4));
        chk("tog_we", {31'b0, ram_we_o}, 32'd0);
        issued++;
      end
      if (pop_now != 0) begin
        chk($sformatf("tog_rdata%0d", popped), rd_data_o, 32'h1000 + popped);
        popped++;
      end
      if (done_o) done_cyc = cyc;
      @(posedge clk); #1;
      rd_ready_i = ~rd_ready_i;
    end
    rd_ready_i = 1'b1;
    chk("tog_issued", issued, 8);
    chk("tog_popped", popped, 8);
    chk("tog_stalled", {31'b0, stalls > 0}, 32'd1);
    chk("tog_done_seen", {31'b0, done_cyc != 0}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
    wr_valid_i = 1'b0; wr_data_i = '0; wr_be_i = '0; rd_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
    chk("rst_outputs", {26'b0, busy_o, done_o, ram_en_o, ram_we_o, rd_valid_o, wr_ready_o}, 32'd0);
    chk("rst_ram_addr", {10'b0, ram_addr_o}, 32'd0);
    chk("rst_rd_data", rd_data_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    vecs[0] = mkv(1'b1, 22'h100000, 8'd4, 32'h000000A0, 4'hF, 22'h100000);
    vecs[1] = mkv(1'b0, 22'h100000, 8'd4, 32'h000000A0, 4'hF, 22'h100000);
    vecs[2] = mkv(1'b1, 22'h3FFFFC, 8'd2, 32'h000000B0, 4'hF, 22'h3FFFFC);
    vecs[3] = mkv(1'b0, 22'h3FFFFC, 8'd2, 32'h000000B0, 4'hF, 22'h3FFFFC);
    vecs[4] = mkv(1'b1, 22'h100003, 8'd1, 32'h555566C0, 4'h3, 22'h100000);
    vecs[5] = mkv(1'b0, 22'h100001, 8'd1, 32'h000066C0, 4'hF, 22'h100000);
    vecs[6] = mkv(1'b1, 22'h100000, 8'd0, 32'h00000000, 4'hF, 22'h100000);
    vecs[7] = mkv(1'b1, 22'h200000, 8'd8, 32'h00001000, 4'hF, 22'h200000);
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Zero-length command: busy only during the DONE cycle.
    send_cmd(1'b1, 22'h100000, 8'd0);
    @(negedge clk);
    chk("len0_busy_hs", {31'b0, busy_o}, 32'd0);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    @(negedge clk);
    chk("len0_done_cycle", {28'b0, busy_o, done_o, ram_en_o, cmd_ready_o}, 32'b1100);
    @(posedge clk); #1;
    @(negedge clk);
    chk("len0_after", {29'b0, busy_o, done_o, cmd_ready_o}, 32'b001);

    toggle_read();

    // Reset with one word buffered and one in flight.
    send_cmd(1'b0, 22'h200000, 8'd4);
    rd_ready_i = 1'b0;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_pre_valid", {31'b0, rd_valid_o}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rd_valid", {31'b0, rd_valid_o}, 32'd0);
    chk("abort_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
    chk("abort_done", {31'b0, done_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_quiet", {29'b0, done_o, rd_valid_o, busy_o}, 32'd0);
    end
    rd_ready_i = 1'b1;
    run_vec(mkv(1'b0, 22'h200004, 8'd1, 32'h00001001, 4'hF, 22'h200004), 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sp_ram_burst_master.md
Name: sp_ram_burst_master

Overview:
- Initiator for the single-port RAM interface: en/addr/wdata/we/be outputs, rdata returned one cycle after a read enable.
- Accepts block commands: base byte address, word count, direction.
- Write bursts take data from a valid/ready stream; read bursts deliver data to a valid/ready stream.
- Sits between a core-side DMA/accelerator port and a data RAM bank. Emits absolute byte addresses; the RAM applies its own base offset.

Parameters:
ADDR_WIDTH, 22, byte-address width of the RAM port
DATA_WIDTH, 32, word width; multiple of 8
LEN_WIDTH, 8, width of the burst word-count field

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when high with cmd_valid_i
cmd_write_i  in  1  1 = write burst, 0 = read burst
cmd_addr_i  in  ADDR_WIDTH  start byte address; low $clog2(DATA_WIDTH/8) bits ignored
cmd_len_i  in  LEN_WIDTH  number of words
wr_valid_i  in  1  write data valid
wr_ready_o  out  1  write data accepted
wr_data_i  in  DATA_WIDTH  write word
wr_be_i  in  DATA_WIDTH/8  byte enables for write word
rd_valid_o  out  1  read data valid
rd_ready_i  in  1  read data consumed
rd_data_o  out  DATA_WIDTH  read word
done_o  out  1  one-cycle pulse at burst completion
busy_o  out  1  high from command accept until done_o, inclusive
ram_en_o  out  1  RAM enable
ram_addr_o  out  ADDR_WIDTH  RAM byte address, word aligned
ram_wdata_o  out  DATA_WIDTH  RAM write data
ram_we_o  out  1  RAM write enable
ram_be_o  out  DATA_WIDTH/8  RAM byte enables
ram_rdata_i  in  DATA_WIDTH  RAM read data, valid the cycle after a read enable

Behaviour:
- Reset: state IDLE; all outputs 0 except cmd_ready_o, which is 1. Read buffer is emptied, counters and in-flight flag are cleared.
- Reset mid-burst aborts the burst. No done_o. Any RAM response returned after reset is discarded.
- States:
  - IDLE: cmd_ready_o=1. On cmd handshake, latch the address with low bits zeroed and latch cnt=cmd_len_i.
    - cnt==0: go to DONE.
    - Otherwise go to WRITE or READ.
  - WRITE:
    - wr_ready_o=1.
    - ram_en_o=ram_we_o=wr_valid_i, combinational pass-through.
    - ram_wdata_o=wr_data_i and ram_be_o=wr_be_i.
    - Each beat: addr += DATA_WIDTH/8, wrapping mod 2^ADDR_WIDTH; cnt--. The last beat goes to DONE.
  - READ:
    - Issue ram_en_o=1, ram_we_o=0, ram_be_o=all-ones when remaining>0 and (buffer occupancy + in-flight) < 2.
    - In-flight flag is set for one cycle. On the next cycle ram_rdata_i is pushed into a 2-entry FIFO.
    - rd_data_o is the FIFO head; rd_valid_o = FIFO non-empty.
    - Pop on rd_valid_o & rd_ready_i.
    - Simultaneous push and pop is legal.
    - Go to DONE when all words are issued, none is in flight, and the FIFO is empty.
  - DONE: done_o=1 for exactly one cycle, busy_o=1, then IDLE.
- cmd_ready_o=0 in every state except IDLE. Back-to-back commands are separated by at least the DONE cycle.
- Sustained throughput: 1 word/cycle in both directions when the stream side never stalls.
- Read latency: first rd_valid_o 2 cycles after the command handshake.
- wr_ready_o=0 and ram_we_o=0 outside WRITE.
- RAM write outputs are never driven during READ.

Test Plan:
- Write 4 words, cmd_addr=0x100000, data 0xA0..0xA3, be=0xF, wr_valid held high → ram_en/we high 4 consecutive cycles at addresses 0x100000, 0x100004, 0x100008, 0x10000C; done_o one cycle after the last beat.
- Read 4 words from 0x100000 against a RAM model holding 0xA0..0xA3, rd_ready=1 → rd_data 0xA0..0xA3 in order on consecutive cycles, first one 2 cycles after the command; then done_o.
- Read 8 words with rd_ready toggling 1/0 each cycle → no lost or duplicated word; occupancy plus in-flight never exceeds 2; ram_en stalls while the buffer is full.
- cmd_len=0, write → no RAM access; done_o the cycle after the handshake; busy_o high for that cycle only.
- cmd_addr=0x3FFFFC (ADDR_WIDTH=22), length 2, write → addresses 0x3FFFFC then 0x000000. cmd_addr=0x100003 → first address 0x100000.
- rst asserted mid-read with 1 word in flight and 1 buffered → next cycle rd_valid_o=0, cmd_ready_o=1, no done_o; a following 1-word read returns the correct data.
